// File: rtl/dcache_assoc.sv
// 2-way set-associative write-back data cache with LRU replacement and write-allocate.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_assoc #(
   parameter int ADDR_W      = 8,
   parameter int SETS        = 4,
   parameter int BLOCK_WORDS = 4,
   localparam int OFF_W      = $clog2(BLOCK_WORDS),
   localparam int IDX_W      = $clog2(SETS),
   localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
   localparam int BLK_W      = 8 * BLOCK_WORDS
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_W-1:0]       address,
   input  logic [7:0]              writedata,
   output logic [7:0]              readdata,
   output logic                    busywait,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDR_W-OFF_W-1:0] mem_address,
   output logic [BLK_W-1:0]        mem_writedata,
   input  logic [BLK_W-1:0]        mem_readdata,
   input  logic                    mem_busywait
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]             hit_count,
   output logic [15:0]             miss_count
`endif
);

   // state      | meaning
   // S_IDLE     | serve hits; detect misses and pick a victim way
   // S_WRITEBACK| write dirty victim block to memory
   // S_FETCH    | read requested block from memory into the victim way
   // S_FILL     | one quiet cycle before the retried access hits
   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_FILL} state_t;

   state_t state, state_nx;

   logic [TAG_W-1:0] tag_in;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;

   logic [1:0]       valid  [SETS];
   logic [1:0]       dirty  [SETS];
   logic             lru    [SETS];
   logic [TAG_W-1:0] tags   [SETS][2];
   logic [BLK_W-1:0] blocks [SETS][2];

   logic req, hit0, hit1, hit, hit_way;
   logic victim_c, victim_q, fill_done, fill_q, busy;

   assign tag_in = address[ADDR_W-1 -: TAG_W];
   assign idx    = address[OFF_W +: IDX_W];
   assign off    = address[OFF_W-1:0];
   assign req    = read | write;

   always_comb begin
      hit0     = valid[idx][0] && (tags[idx][0] == tag_in);
      hit1     = valid[idx][1] && (tags[idx][1] == tag_in);
      hit      = req && (state == S_IDLE) && (hit0 || hit1);
      hit_way  = ~hit0;
      victim_c = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);
   end

   assign fill_done     = (state == S_FETCH) && !mem_busywait;
   assign readdata      = reset ? blocks[idx][hit_way][{off, 3'b000} +: 8] : 8'h00;
   assign busywait      = reset & busy;
   assign mem_writedata = blocks[idx][victim_q];

   always_comb begin
      state_nx    = state;
      busy        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      case (state)
         S_IDLE: begin
            if (req && !hit) begin
               busy = 1'b1;
               if (valid[idx][victim_c] && dirty[idx][victim_c]) state_nx = S_WRITEBACK;
               else                                              state_nx = S_FETCH;
            end
         end
         S_WRITEBACK: begin
            busy        = 1'b1;
            mem_write   = 1'b1;
            mem_address = {tags[idx][victim_q], idx};
            if (!mem_busywait) state_nx = S_FETCH;
         end
         S_FETCH: begin
            busy        = 1'b1;
            mem_read    = 1'b1;
            mem_address = {tag_in, idx};
            if (!mem_busywait) state_nx = S_FILL;
         end
         S_FILL: begin
            busy     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         victim_q <= 1'b0;
         fill_q   <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= 2'b00;
            dirty[s] <= 2'b00;
            lru[s]   <= 1'b0;
         end
      end else begin
         state  <= state_nx;
         fill_q <= (state == S_FILL);
         // Victim is frozen for the whole miss so WRITEBACK and FETCH agree.
         if (state == S_IDLE) victim_q <= victim_c;
         if (hit) begin
            lru[idx] <= ~hit_way;
            if (write) dirty[idx][hit_way] <= 1'b1;
         end
         if (fill_done) begin
            valid[idx][victim_q] <= 1'b1;
            dirty[idx][victim_q] <= 1'b0;
            lru[idx]             <= ~victim_q;
         end
      end
   end

   // Tags and data are left uninitialised by reset; valid bits gate their use.
   always_ff @(posedge clock) begin
      if (hit && write) blocks[idx][hit_way][{off, 3'b000} +: 8] <= writedata;
      if (fill_done) begin
         blocks[idx][victim_q] <= mem_readdata;
         tags[idx][victim_q]   <= tag_in;
      end
   end

`ifdef DCACHE_STATS_EN
   // A hit in the cycle right after FILL is the retry of a counted miss.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_count  <= 16'h0000;
         miss_count <= 16'h0000;
      end else begin
         if (hit && !fill_q && hit_count != 16'hFFFF) hit_count <= hit_count + 16'h0001;
         if ((state == S_IDLE) && req && !hit && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed scenarios then random accesses checked against
// a flat golden byte memory and a per-set recency-list residency model.
module tb_dcache_assoc;

   logic        clock = 1'b0;
   logic        reset;
   logic        read, write;
   logic [7:0]  address, writedata, readdata;
   logic        busywait, mem_read, mem_write, mem_busywait;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   dcache_assoc dut (
      .clock(clock), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata),
      .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [7:0] init_byte(input logic [7:0] a);
      if (a < 8'd4) return 8'h11 * (a + 8'd1);
      return a * 8'd37 + 8'd5;
   endfunction

   // backing memory: written bytes override the initial pattern
   logic [7:0] mem_arr [256];
   bit         wr_flag [256];
   int         lat_cnt = 0;
   bit         hold_mem = 1'b0;

   assign mem_busywait = (mem_read || mem_write) && (lat_cnt != 0 || hold_mem);

   always_comb begin
      logic [7:0] ba;
      ba = 8'h00;
      mem_readdata = '0;
      for (int k = 0; k < 4; k++) begin
         ba = {mem_address, k[1:0]};
         mem_readdata[8*k +: 8] = wr_flag[ba] ? mem_arr[ba] : init_byte(ba);
      end
   end

   always @(posedge clock) begin
      if (mem_read || mem_write) begin
         if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
         else if (!hold_mem) begin
            if (mem_write)
               for (int k = 0; k < 4; k++) begin
                  mem_arr[{mem_address, k[1:0]}] <= mem_writedata[8*k +: 8];
                  wr_flag[{mem_address, k[1:0]}] <= 1'b1;
               end
            lat_cnt <= $urandom_range(0, 3);
         end
      end else lat_cnt <= $urandom_range(0, 3);
   end

   // reference model
   logic [7:0] gold [256];
   int         m_cnt [4];
   logic [3:0] m_mru [4];
   logic [3:0] m_lru [4];
   bit         dirty_blk [64];
   int         m_hits = 0;
   int         m_miss = 0;

   function automatic bit m_hit(input logic [3:0] t, input logic [1:0] i);
      return (m_cnt[i] >= 1 && m_mru[i] == t) || (m_cnt[i] == 2 && m_lru[i] == t);
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 256; a++) gold[a] = wr_flag[a] ? mem_arr[a] : init_byte(8'(a));
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      for (int b = 0; b < 64; b++) dirty_blk[b] = 1'b0;
      m_hits = 0;
      m_miss = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   endtask

   task automatic do_access(input logic wr, input logic rd, input logic [7:0] a,
                            input logic [7:0] d, output logic [5:0] wb_a,
                            output logic [31:0] wb_d, output logic [5:0] rd_a);
      logic [3:0] t;
      logic [1:0] i;
      bit hit_exp, exp_wb, wb_seen, rd_seen;
      logic [7:0] vb;
      int cyc;
      t = a[7:4]; i = a[3:2];
      wb_a = '0; wb_d = '0; rd_a = '0;
      hit_exp = m_hit(t, i);
      @(negedge clock);
      read = rd; write = wr; address = a; writedata = d;
      #1;
      if (hit_exp) begin
         m_hits++;
         chk("busy_on_hit", busywait, 0);
         chk("memrd_on_hit", mem_read, 0);
         chk("memwr_on_hit", mem_write, 0);
      end else begin
         m_miss++;
         exp_wb = (m_cnt[i] == 2) && dirty_blk[{m_lru[i], i}];
         chk("busy_on_miss", busywait, 1);
         wb_seen = 0; rd_seen = 0; cyc = 0;
         while (busywait === 1'b1 && cyc < 100) begin
            if (mem_write === 1'b1 && !wb_seen) begin
               wb_seen = 1; wb_a = mem_address; wb_d = mem_writedata;
               vb = {m_lru[i], i, 2'b00};
               chk("wb_addr", mem_address, {m_lru[i], i});
               chk("wb_data", mem_writedata,
                   {gold[vb + 8'd3], gold[vb + 8'd2], gold[vb + 8'd1], gold[vb]});
            end
            if (mem_read === 1'b1 && !rd_seen) begin
               rd_seen = 1; rd_a = mem_address;
               chk("fetch_addr", mem_address, a[7:2]);
            end
            @(negedge clock); #1; cyc++;
         end
         if (cyc >= 100) begin
            chk("miss_timeout", cyc, 0);
            finish_run();
         end
         chk("wb_seen", wb_seen, exp_wb);
         chk("fetch_seen", rd_seen, 1);
         if (m_cnt[i] == 2) begin
            dirty_blk[{m_lru[i], i}] = 1'b0;
            m_lru[i] = m_mru[i];
         end else if (m_cnt[i] == 1) begin
            m_lru[i] = m_mru[i];
            m_cnt[i] = 2;
         end else m_cnt[i] = 1;
         m_mru[i] = t;
      end
      if (!wr) chk("rdata", readdata, gold[a]);
      @(posedge clock);
      if (m_cnt[i] == 2 && m_lru[i] == t) begin
         m_lru[i] = m_mru[i];
         m_mru[i] = t;
      end
      if (wr) begin
         gold[a] = d;
         dirty_blk[a[7:2]] = 1'b1;
      end
   endtask

   initial begin
      logic [5:0]  wa, ra;
      logic [31:0] wd;
      logic [7:0]  a;
      int r, cyc;

      reset = 1'b0; read = 1'b1; write = 1'b0; address = 8'h00; writedata = 8'h00;
      model_reset();
      #12;
      chk("rst_busywait", busywait, 0);
      chk("rst_memrd", mem_read, 0);
      chk("rst_memwr", mem_write, 0);
      chk("rst_rdata", readdata, 0);
      read = 1'b0;
      @(negedge clock); reset = 1'b1;

      // cold read miss
      do_access(0, 1, 8'h00, 8'h00, wa, wd, ra);
      #1;
      chk("cold_fetch_addr", ra, 6'h00);
      chk("cold_rdata", readdata, 8'h11);
      chk("cold_busy", busywait, 0);

      // read hit, same cycle data
      do_access(0, 1, 8'h03, 8'h00, wa, wd, ra);
      #1;
      chk("hit_rdata", readdata, 8'h44);

      // dirty eviction
      do_access(1, 0, 8'h01, 8'hAA, wa, wd, ra);
      do_access(0, 1, 8'h10, 8'h00, wa, wd, ra);
      chk("way1_fetch_addr", ra, 6'h04);
      do_access(0, 1, 8'h20, 8'h00, wa, wd, ra);
      chk("evict_wb_addr", wa, 6'h00);
      chk("evict_wb_data", wd, 32'h4433AA11);
      chk("evict_fetch_addr", ra, 6'h08);
`ifdef DCACHE_STATS_EN
      #1;
      chk("dir_hit_count", hit_count, 2);
      chk("dir_miss_count", miss_count, 3);
`endif

      // reset in the middle of a fetch
      hold_mem = 1'b1;
      @(negedge clock);
      read = 1'b1; write = 1'b0; address = 8'h00;
      #1; cyc = 0;
      while (mem_read !== 1'b1 && cyc < 50) begin
         @(negedge clock); #1; cyc++;
      end
      chk("fetch_reached", mem_read, 1);
      #1; reset = 1'b0; read = 1'b0;
      #1;
      chk("abort_memrd", mem_read, 0);
      chk("abort_busy", busywait, 0);
      chk("abort_rdata", readdata, 0);
      hold_mem = 1'b0;
      model_reset();
      @(negedge clock); reset = 1'b1;
      do_access(0, 1, 8'h00, 8'h00, wa, wd, ra);
      chk("post_rst_fetch", ra, 6'h00);

      // random traffic over 4 tags per set
      for (int n = 0; n < 250; n++) begin
         a = 8'($urandom_range(0, 63));
         r = $urandom_range(0, 9);
         if (r <= 5)      do_access(0, 1, a, 8'h00, wa, wd, ra);
         else if (r <= 8) do_access(1, 0, a, 8'($urandom), wa, wd, ra);
         else             do_access(1, 1, a, 8'($urandom), wa, wd, ra);
      end
      @(negedge clock);
      read = 1'b0; write = 1'b0;
`ifdef DCACHE_STATS_EN
      #1;
      chk("rnd_hit_count", hit_count, m_hits);
      chk("rnd_miss_count", miss_count, m_miss);
`endif
      finish_run();
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
